fadd_normalize_round: RTL and testbench

FADD_NORMALIZE_ROUND -- requirements
Module: fadd_normalize_round

---
 rtl/fadd_normalize_round.sv | 110 +++++++++++
 tb/tb_fadd_normalize_round.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_normalize_round.sv
// Normalize, round and pack stage behind the single-precision prefix adder (2-stage pipeline).
// Build option FADD_ROUND_RNE_EN: defined -> round-to-nearest-even, undefined -> truncate.
module fadd_normalize_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] sum,
    input  logic [7:0]  exp_in,
    input  logic        sign_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  flags
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic [31:0] sum;
        logic [7:0]  exp;
        logic        sign;
        logic [4:0]  lz;
    } s1_t;

    logic [STAGES:1]    vld_pipe;
    logic               adv;
    s1_t                s1;
    logic [4:0]         lz;
    logic [31:0]        norm;
    logic signed [9:0]  exp_n;
    logic signed [9:0]  exp_f;
    logic [23:0]        frac_r;
    logic               rnd_up;
    logic [31:0]        res_n;
    logic [2:0]         flg_n;
    logic               unused_norm;

    // Distance of the leading one from bit30; an all-zero field reports 31.
    function automatic logic [4:0] lzc31(input logic [30:0] v);
        logic [4:0] n;
        n = 5'd31;
        for (int i = 0; i <= 30; i++)
            if (v[i]) n = 5'(30 - i);
        return n;
    endfunction

    assign lz        = lzc31(sum[30:0]);
    assign adv       = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1       <= '0;
            result   <= '0;
            flags    <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            if (in_valid)
                s1 <= '{sum: sum, exp: exp_in, sign: sign_in, lz: lz};
            if (vld_pipe[1]) begin
                result <= res_n;
                flags  <= flg_n;
            end
        end
    end

    // After normalization norm[30] is the hidden bit, [29:7] fraction, [6] G, [5] R, [4:0] S.
    always_comb begin
        norm  = '0;
        exp_n = '0;
        if (s1.sum[31]) begin
            norm  = {1'b0, s1.sum[31:2], s1.sum[1] | s1.sum[0]};
            exp_n = {2'b00, s1.exp} + 10'd1;
        end else begin
            norm  = s1.sum << s1.lz;
            exp_n = {2'b00, s1.exp} - {5'd0, s1.lz};
        end

`ifdef FADD_ROUND_RNE_EN
        rnd_up = norm[6] & (norm[5] | (|norm[4:0]) | norm[7]);
`else
        rnd_up = 1'b0;
`endif

        frac_r = {1'b0, norm[29:7]} + {23'd0, rnd_up};
        exp_f  = frac_r[23] ? exp_n + 10'sd1 : exp_n;

        res_n = {s1.sign, exp_f[7:0], frac_r[22:0]};
        flg_n = 3'b000;
        if (s1.sum == '0) begin
            res_n = '0;
            flg_n = 3'b001;
        end else if (exp_f >= 10'sd255) begin
            res_n = {s1.sign, 8'hFF, 23'd0};
            flg_n = 3'b100;
        end else if (exp_f <= 10'sd0) begin
            res_n = {s1.sign, 31'd0};
            flg_n = 3'b011;
        end
    end

`ifdef FADD_ROUND_RNE_EN
    assign unused_norm = ^norm[31:30];
`else
    assign unused_norm = ^{norm[31:30], norm[6:0]};
`endif

endmodule

// File: tb/tb_fadd_normalize_round.sv
// Randomized bench for fadd_normalize_round: scoreboard against an exact-arithmetic model.
module tb_fadd_normalize_round;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] sum;
    logic [7:0]  exp_in;
    logic        sign_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  flags;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] r;
        logic [2:0]  f;
    } exp_t;

    exp_t        sb[$];
    logic        hold_chk = 1'b0;
    logic [31:0] held_r;
    logic [2:0]  held_f;

    fadd_normalize_round dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .exp_in(exp_in), .sign_in(sign_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Value = sum * 2^(exp_in-127-30); keep 24 significant bits, round exactly on the remainder.
    function automatic exp_t model(input logic [31:0] s, input logic [7:0] e, input logic sg);
        exp_t   o;
        int     p;
        int     ue;
        int     sh;
        longint m;
        longint rem;
        longint half;
        o    = '0;
        sh   = 0;
        rem  = 0;
        half = 0;
        if (s == 32'd0) begin
            o.f = 3'b001;
            return o;
        end
        p = 31;
        while (!s[p]) p--;
        ue = int'(e) + p - 30;
        if (p >= 23) begin
            sh   = p - 23;
            m    = longint'(s) >> sh;
            rem  = longint'(s) & ((64'sd1 << sh) - 1);
            half = (sh == 0) ? 64'sd0 : (64'sd1 << (sh - 1));
        end else begin
            m = longint'(s) << (23 - p);
        end
`ifdef FADD_ROUND_RNE_EN
        if (half != 0 && (rem > half || (rem == half && m[0]))) m++;
`endif
        if (m == (64'sd1 << 24)) begin
            m = m >> 1;
            ue++;
        end
        if (ue >= 255) begin
            o.r = {sg, 8'hFF, 23'd0};
            o.f = 3'b100;
        end else if (ue <= 0) begin
            o.r = {sg, 31'd0};
            o.f = 3'b011;
        end else begin
            o.r = {sg, ue[7:0], m[22:0]};
            o.f = 3'b000;
        end
        return o;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_result", result, held_r);
                chk("hold_flags", flags, held_f);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_result", result, e.r);
                    chk("out_flags", flags, e.f);
                end
            end
            if (in_valid && in_ready) sb.push_back(model(sum, exp_in, sign_in));
            hold_chk = out_valid && !out_ready;
            held_r   = result;
            held_f   = flags;
        end
    end

    task automatic direct(input string nm, input logic [31:0] s, input logic [7:0] e,
                          input logic sg, input logic [31:0] er, input logic [2:0] ef);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; sum = s; exp_in = e; sign_in = sg; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_lat"}, 64'(n), 2);
        chk({nm, "_res"}, result, er);
        chk({nm, "_flg"}, flags, ef);
    endtask

    logic [31:0] vs[3];
    int          k;
    int          nv;
    logic        acc;

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sum = '0; exp_in = '0; sign_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("idle_in_ready", in_ready, 1);

        chk("model_029", model(32'h8000_0000, 8'd127, 1'b0), {32'h4000_0000, 3'b000});
        chk("model_030", model(32'h2000_0000, 8'd127, 1'b0), {32'h3F00_0000, 3'b000});
`ifdef FADD_ROUND_RNE_EN
        chk("model_031", model(32'h7FFF_FFC0, 8'd127, 1'b0), {32'h4000_0000, 3'b000});
`else
        chk("model_031", model(32'h7FFF_FFC0, 8'd127, 1'b0), {32'h3FFF_FFFF, 3'b000});
`endif
        chk("model_032", model(32'h0040_0000, 8'd1, 1'b0), {32'h0000_0000, 3'b011});

        direct("ovf_shift", 32'h8000_0000, 8'd127, 1'b0, 32'h4000_0000, 3'b000);
        direct("lz1",       32'h2000_0000, 8'd127, 1'b0, 32'h3F00_0000, 3'b000);
        direct("zero",      32'h0000_0000, 8'd127, 1'b1, 32'h0000_0000, 3'b001);
`ifdef FADD_ROUND_RNE_EN
        direct("round",     32'h7FFF_FFC0, 8'd127, 1'b0, 32'h4000_0000, 3'b000);
`else
        direct("round",     32'h7FFF_FFC0, 8'd127, 1'b0, 32'h3FFF_FFFF, 3'b000);
`endif
        direct("inf",       32'h8000_0000, 8'd254, 1'b1, 32'hFF80_0000, 3'b100);
        direct("uflow",     32'h0040_0000, 8'd1,   1'b0, 32'h0000_0000, 3'b011);

        // Stall: three inputs offered against a blocked output.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) vs[i] = $urandom | 32'h4000_0000;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; sum = vs[k]; exp_in = 8'd100 + 8'(k); sign_in = k[0];
            acc = in_ready;
            @(posedge clk);
            if (acc) k++;
            #1;
        end
        chk("stall_accepted", 64'(k), 2);
        chk("stall_in_ready", in_ready, 0);
        out_ready = 1'b1;
        nv = 0;
        for (int c = 0; c < 3; c++) begin
            if (out_valid) nv++;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        chk("drain_consecutive", 64'(nv), 3);
        repeat (2) @(posedge clk);

        // Randomized traffic with boundary-weighted exponents.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sum       = $urandom >> $urandom_range(0, 32);
            if ($urandom_range(0, 7) == 0) sum = 32'hFFFF_FFFF >> $urandom_range(0, 8);
            case ($urandom_range(0, 6))
                0: exp_in = 8'd0;
                1: exp_in = 8'd1;
                2: exp_in = 8'(30 - $urandom_range(0, 29));
                3: exp_in = 8'd254;
                4: exp_in = 8'd255;
                default: exp_in = 8'($urandom);
            endcase
            sign_in = $urandom_range(0, 1) == 1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        #1 chk("rand_drained", 64'(sb.size()), 0);

        // Reset with two operations in flight.
        @(posedge clk); #1;
        in_valid = 1'b1; sum = 32'h4000_0000; exp_in = 8'd127; sign_in = 1'b0;
        @(posedge clk); #1;
        sum = 32'h6000_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1 chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        nv = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_valid) nv++;
        end
        chk("flushed_no_output", 64'(nv), 0);
        direct("post_rst", 32'h8000_0000, 8'd127, 1'b0, 32'h4000_0000, 3'b000);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
